// File: rtl/led_sequencer_if.sv
// LED sequencer control/status bundle.
// Controller drives enable, mode and divider; sequencer returns pattern and step.
interface led_sequencer_if #(
  parameter int NUM_LEDS  = 4,
  parameter int DIV_WIDTH = 23
);
  logic                 en;
  logic [1:0]           mode;
  logic [DIV_WIDTH-1:0] step_div;
  logic [NUM_LEDS-1:0]  data;
  logic                 step;

  modport master (
    output en, mode, step_div,
    input  data, step
  );

  modport slave (
    input  en, mode, step_div,
    output data, step
  );
endinterface

// File: rtl/led_sequencer.sv
// Prescaled LED pattern generator: shift down/up, bounce, binary count.
// Registered outputs; a mode change reloads the pattern ahead of any tick.
module led_sequencer #(
  parameter int NUM_LEDS  = 4,
  parameter int DIV_WIDTH = 23
) (
  input  logic            clk_in,
  input  logic            rst_n,
  led_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    SHIFT_DOWN = 2'b00,
    SHIFT_UP   = 2'b01,
    BOUNCE     = 2'b10,
    BINARY     = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic [NUM_LEDS-1:0] ONE =
    NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] MSB_ONLY =
    ONE << (NUM_LEDS - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE =
    DIV_WIDTH'(1);

  mode_e                mode_in;
  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d, dir_a;
  logic                 init_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]  data_q, data_d;
  logic [NUM_LEDS-1:0]  adv, bnc;
  logic                 step_q, step_d;
  logic                 tick, reload;
  logic                 onehot, go_right;

  assign mode_in = mode_e'(bus.mode);

  // init_q masks the first-cycle capture of mode so it never reloads
  assign reload = init_q && (mode_in != mode_q);
  assign tick   = bus.en && (cnt_q >= bus.step_div);

  assign onehot = (data_q != '0) &&
    ((data_q & (data_q - ONE)) == '0);

  assign go_right = (dir_q == DIR_DOWN) ?
    !data_q[0] : data_q[NUM_LEDS-1];

  assign bnc = go_right ?
    (data_q >> 1) : (data_q << 1);

  always_comb begin
    adv   = data_q;
    dir_a = dir_q;
    unique case (mode_q)
      SHIFT_DOWN: begin
        adv = onehot ?
          {data_q[0], data_q[NUM_LEDS-1:1]} :
          MSB_ONLY;
      end
      SHIFT_UP: begin
        adv = onehot ?
          {data_q[NUM_LEDS-2:0], data_q[NUM_LEDS-1]} :
          MSB_ONLY;
      end
      BOUNCE: begin
        if (onehot) begin
          adv = bnc;
          if (bnc[0])
            dir_a = DIR_UP;
          else if (bnc[NUM_LEDS-1])
            dir_a = DIR_DOWN;
        end else begin
          adv   = MSB_ONLY;
          dir_a = DIR_DOWN;
        end
      end
      BINARY: begin
        adv = data_q + ONE;
      end
    endcase
  end

  always_comb begin
    mode_d = mode_in;
    cnt_d  = cnt_q;
    data_d = data_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (reload) begin
      data_d = (mode_in == BINARY) ? '0 : MSB_ONLY;
      cnt_d  = '0;
      dir_d  = DIR_DOWN;
    end else if (tick) begin
      data_d = adv;
      cnt_d  = '0;
      dir_d  = dir_a;
      step_d = 1'b1;
    end else if (bus.en) begin
      cnt_d  = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      mode_q <= SHIFT_DOWN;
      cnt_q  <= '0;
      data_q <= MSB_ONLY;
      dir_q  <= DIR_DOWN;
      step_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign bus.data = data_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: 4-LED and 2-LED builds.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_led_sequencer;

  logic clk;
  logic rst_n;
  logic rst2_n;

  led_sequencer_if #(.NUM_LEDS(4), .DIV_WIDTH(4)) if4 ();
  led_sequencer_if #(.NUM_LEDS(2), .DIV_WIDTH(1)) if2 ();

  led_sequencer #(.NUM_LEDS(4), .DIV_WIDTH(4)) dut4 (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (if4)
  );

  led_sequencer #(.NUM_LEDS(2), .DIV_WIDTH(1)) dut2 (
    .clk_in (clk),
    .rst_n  (rst2_n),
    .bus    (if2)
  );

  typedef struct {
    int         cyc;
    bit         id;
    logic [3:0] d;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b",
               nm, cyc_cnt, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
      me = q.pop_front();
      if (me.id) begin
        chk({me.nm, "_data"}, {2'b00, if2.data}, me.d);
        chk({me.nm, "_step"}, {3'b000, if2.step},
            {3'b000, me.s});
      end else begin
        chk({me.nm, "_data"}, if4.data, me.d);
        chk({me.nm, "_step"}, {3'b000, if4.step},
            {3'b000, me.s});
      end
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit id,
                      input logic [3:0] d,
                      input logic s,
                      input string nm);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.id  = id;
    e.d   = d;
    e.s   = s;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic cyc4(input logic [3:0] d,
                      input logic s,
                      input string nm);
    push(1'b0, d, s, nm);
    tick1();
  endtask

  task automatic cyc2(input logic [1:0] d,
                      input logic s,
                      input string nm);
    push(1'b1, {2'b00, d}, s, nm);
    tick1();
  endtask

  logic [3:0] down_seq [4] =
    '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] bnc_seq [8] =
    '{4'b0100, 4'b0010, 4'b0001, 4'b0010,
      4'b0100, 4'b1000, 4'b0100, 4'b0010};
  logic [3:0] up_seq [4] =
    '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] b2_seq [8] =
    '{2'b10, 2'b01, 2'b01, 2'b10,
      2'b10, 2'b01, 2'b01, 2'b10};
  logic       b2_stp [8] =
    '{1'b0, 1'b1, 1'b0, 1'b1,
      1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    if4.en       = 1'b1;
    if4.mode     = 2'b00;
    if4.step_div = 4'd2;
    if2.en       = 1'b1;
    if2.mode     = 2'b10;
    if2.step_div = 1'b1;
    tick1();
    tick1();
    chk("rst_data", if4.data, 4'b1000);
    chk("rst_step", {3'b000, if4.step}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++)
      cyc4(down_seq[(i / 3) % 4], (i % 3) == 0,
           "shift_down");

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", if4.data, 4'b1000);
    chk("async_rst_step", {3'b000, if4.step}, 4'b0000);
    if4.mode     = 2'b10;
    if4.step_div = 4'd0;
    tick1();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      cyc4(bnc_seq[i], 1'b1, "bounce");

    if4.mode = 2'b11;
    cyc4(4'b0000, 1'b0, "bin_reload");
    for (int i = 1; i <= 16; i++)
      cyc4(4'(i), 1'b1, "binary");

    if4.mode = 2'b01;
    cyc4(4'b1000, 1'b0, "up_reload");
    for (int i = 0; i < 4; i++)
      cyc4(up_seq[i], 1'b1, "shift_up");

    if4.step_div = 4'd5;
    for (int i = 0; i < 3; i++)
      cyc4(4'b1000, 1'b0, "pre_gap");
    if4.en = 1'b0;
    for (int i = 0; i < 7; i++)
      cyc4(4'b1000, 1'b0, "en_low");
    if4.en = 1'b1;
    cyc4(4'b1000, 1'b0, "resume");
    cyc4(4'b1000, 1'b0, "resume");
    cyc4(4'b0001, 1'b1, "resume_tick");
    for (int i = 0; i < 4; i++)
      cyc4(4'b0001, 1'b0, "count_up");
    if4.step_div = 4'd1;
    cyc4(4'b0010, 1'b1, "div_lower");
    cyc4(4'b0010, 1'b0, "div1_wait");
    cyc4(4'b0100, 1'b1, "div1_tick");

    cyc4(4'b0100, 1'b0, "pre_clash");
    if4.mode = 2'b00;
    cyc4(4'b1000, 1'b0, "reload_wins");
    cyc4(4'b1000, 1'b0, "post_reload");
    cyc4(4'b0100, 1'b1, "post_reload_tick");

    chk("n2_rst_data", {2'b00, if2.data}, 4'b0010);
    rst2_n = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc2(b2_seq[i], b2_stp[i], "n2_bounce");

    tick1();
    #2;
    chk("queue_drained", 4'(q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern generator, successor to the fixed 4-LED one-hot switcher.
- A programmable prescaler produces a step tick. On each tick the registered LED pattern advances according to a run-time selectable mode: shift down, shift up, bounce, or binary count.
- Drives board LEDs directly. Also exports a step pulse for other blocks to synchronise to.

Parameters:
- NUM_LEDS, 4, number of LED outputs; legal range ≥2.
- DIV_WIDTH, 23, width of the prescaler counter and of step_div.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low freezes the prescaler and the pattern.
- mode  input  2  pattern mode: 00 SHIFT_DOWN, 01 SHIFT_UP, 10 BOUNCE, 11 BINARY.
- step_div  input  DIV_WIDTH  a step occurs every step_div+1 enabled cycles.
- data  output  NUM_LEDS  registered LED pattern.
- step  output  1  one-cycle pulse, coincident with each pattern update.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data = 1 in the MSB only (100…0).
  - prescaler = 0, step = 0, bounce direction = down.
  - mode_q captures mode on the first clock after release; no reload is triggered by that capture.
- Prescaler:
  - cnt is DIV_WIDTH bits.
  - If en and cnt ≥ step_div: cnt ← 0 and tick = 1. Otherwise, if en: cnt ← cnt+1.
  - The compare is ≥, so lowering step_div below the current cnt still gives a tick on the next enabled cycle.
  - step_div = 0 gives a tick every enabled cycle.
- Step:
  - On a tick, data advances and step goes high on that same edge for exactly one cycle.
  - Otherwise step = 0.
- Mode change:
  - mode is registered into mode_q every cycle.
  - When mode ≠ mode_q, the reload rule applies:
    - data ← mode's initial pattern.
    - cnt ← 0.
    - bounce direction ← down.
    - step = 0.
  - Reload has priority over a coincident tick and applies regardless of en.
- Initial patterns:
  - SHIFT_DOWN, SHIFT_UP, BOUNCE: 100…0.
  - BINARY: 000…0.
- Advance rules, per tick:
  - SHIFT_DOWN: data ← {data[0], data[N-1:1]}, a rotate right, so 1000→0100→0010→0001→1000.
  - SHIFT_UP: rotate left, so 1000→0001→0010→0100→1000.
  - BOUNCE: the single bit moves toward the LSB while direction = down. When it reaches bit 0, direction flips to up and it moves toward the MSB. At the MSB it flips back to down.
    - The end LEDs are held for exactly one step each.
    - Sequence for N=4: 1000,0100,0010,0001,0010,0100,1000,0100…
    - For N=2 it alternates 10,01.
    - The direction flip happens on the same tick that lands on the end bit.
  - BINARY: data ← data+1 modulo 2^NUM_LEDS; 1…1 wraps to 0…0.
- One-hot recovery: in the shift and bounce modes, if data is ever not one-hot (e.g. after leaving BINARY without a reload), the next tick loads 100…0.
- en low:
  - cnt, data and direction hold; step = 0.
  - Ticks resume from the held cnt when en returns high.
- All state is updated on the posedge of clk_in. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset and SHIFT_DOWN: NUM_LEDS=4, DIV_WIDTH=4, mode=00, step_div=2, en=1; release rst_n.
  - data sequence 1000→0100→0010→0001→1000, each held 3 cycles.
  - step pulses exactly once per 3 cycles.
  - Asserting rst_n mid-run returns data to 1000 asynchronously.
- BOUNCE: mode=10, step_div=0.
  - data per cycle: 1000,0100,0010,0001,0010,0100,1000,0100.
  - Ends are never repeated; step high every cycle.
- BINARY wrap and recovery: mode=11, step_div=0.
  - data counts 0000…1111→0000.
  - Switching to SHIFT_UP gives data=1000 the cycle after the change, with no step; then 0001,0010,0100,1000.
- Enable and prescaler: step_div=5, drop en for 7 cycles at cnt=3.
  - data and step frozen during the gap.
  - Next step occurs 2 enabled cycles after en returns.
  - Changing step_div 5→1 while cnt=4 produces a tick on the next enabled cycle.
- Simultaneous events: a mode change on the same cycle a tick is due.
  - Reload wins: data = the new mode's initial pattern, step=0.
  - The next tick occurs step_div+1 cycles later.
- NUM_LEDS=2, DIV_WIDTH=1 build, BOUNCE, step_div=1: data alternates 10,01 every 2 cycles.
